fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port StallF, input, 1, hold fetch stage (driven by hazard unit; ~StallF also enables IF/ID).
REQ-005 SHALL have ports PCSrcD (in, 1) and PcBranchD (in, 32): taken-branch redirect from decode.
REQ-006 SHALL have ports JumpD (in, 1) and PcJumpD (in, 32): jump redirect from decode.
REQ-007 SHALL have imem ports imem_req (out, 1), imem_addr (out, 32), imem_gnt (in, 1), imem_rvalid (in, 1), imem_rdata (in, 32).
REQ-008 SHALL have outputs instr (32), PcPlus4F (32), FetchValidF (1): the instruction word, PC+4, and valid flag feeding IF/ID.

Function
REQ-009 SHALL implement states FETCH, WAIT, HOLD, DISCARD.
REQ-010 Redirect = (PCSrcD|JumpD) & ~StallF; target = PcJumpD if JumpD else PcBranchD (JumpD wins if both asserted).
REQ-011 FETCH: imem_req=1, imem_addr=PC unless redirect; on redirect imem_req=0, PC<=target, stay FETCH; on req&gnt go WAIT.
REQ-012 WAIT, rvalid, no StallF, no redirect: instr=imem_rdata, FetchValidF=1, PC<=PC+4, go FETCH (same cycle).
REQ-013 WAIT, rvalid, redirect: data dropped, bubble out, PC<=target, go FETCH.
REQ-014 WAIT, rvalid, StallF=1: rdata captured in holding buffer, go HOLD.
REQ-015 WAIT, no rvalid: bubble out; redirect -> PC<=target, go DISCARD; else stay WAIT.
REQ-016 HOLD: instr=buffer, FetchValidF=1; StallF=1 -> stay; ~StallF and no redirect -> PC<=PC+4, go FETCH; redirect -> bubble, PC<=target, go FETCH.
REQ-017 DISCARD: imem_req=0, bubble out; rvalid -> drop data, go FETCH; redirect -> PC<=target, stay DISCARD.
REQ-018 Bubble = instr 32'h0000_0000 (sll nop), FetchValidF=0.
REQ-019 PcPlus4F = PC+4 in every state, combinational, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-020 Max one outstanding imem request; imem_req SHALL never assert outside FETCH.
REQ-021 imem_rvalid in FETCH or HOLD is a protocol error; SHALL be ignored.

Reset
REQ-022 On reset: PC=RESET_PC, state=FETCH, buffer=0; outputs: instr=0, FetchValidF=0, imem_req=0 while reset is high, PcPlus4F=RESET_PC+4.
REQ-023 Reset mid-WAIT abandons the outstanding request; a stale rvalid after reset (state FETCH) is ignored per REQ-021.

Configuration
REQ-024 Macro FETCH_PERF_CNT_EN: when defined, adds outputs FetchCnt (32) and BubbleCnt (32), reset to 0, incrementing (wrapping) on each cycle with ~StallF & FetchValidF and ~StallF & ~FetchValidF respectively; when undefined those ports and counters are absent, all other behaviour identical.

Structure
REQ-025 Shared package mips_pkg SHALL hold fetch_state_t enum, NOP_INSTR constant, and default RESET_PC.
REQ-026 One sub-module pc_reg (32-bit, async reset to RESET_PC, load enable) SHALL hold the PC.

Verification
REQ-027 Reset, gnt=1, rvalid one cycle after grant, data 0x2008_0005 -> instr=0x2008_0005, FetchValidF=1, PC 0x0->0x4; next imem_addr=0x4.
REQ-028 rvalid with StallF=1 for 3 cycles, data 0x8C09_0000 -> HOLD, instr stable 3 cycles, no imem_req; StallF drops -> PC advances by 4 once.
REQ-029 PCSrcD=1, PcBranchD=0x40 while in WAIT with no rvalid -> DISCARD; later rvalid data dropped (bubble); next imem_addr=0x40.
REQ-030 PCSrcD=1 and JumpD=1 together (PcBranchD=0x40, PcJumpD=0x80) in FETCH -> imem_req=0, next imem_addr=0x80.
REQ-031 Redirect asserted with StallF=1 -> ignored, PC unchanged; PC=0xFFFF_FFFC -> PcPlus4F=0x0.
REQ-032 Reset asserted mid-WAIT, stale rvalid next cycle -> ignored; first request to RESET_PC; with FETCH_PERF_CNT_EN counters read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS pipeline front end.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: async reset to RESET_PC, loads d when en is high.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= RESET_PC;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a single-outstanding imem handshake and redirect handling.
// Optional FETCH_PERF_CNT_EN adds fetch/bubble cycle counters.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PcBranchD,
    input  logic        JumpD,
    input  logic [31:0] PcJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] PcPlus4F,
    output logic        FetchValidF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCnt,
    output logic [31:0] BubbleCnt
`endif
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_d, target, hold_buf;
    logic         pc_en, buf_en, redirect;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc)
    );

    // A stalled decode stage cannot redirect; JumpD has priority over a branch.
    assign redirect  = (PCSrcD | JumpD) & ~StallF;
    assign target    = JumpD ? PcJumpD : PcBranchD;
    assign PcPlus4F  = pc + 32'd4;
    assign imem_addr = pc;

    always_comb begin
        state_n     = state;
        instr       = NOP_INSTR;
        FetchValidF = 1'b0;
        imem_req    = 1'b0;
        pc_en       = 1'b0;
        pc_d        = PcPlus4F;
        buf_en      = 1'b0;
        case (state)
            FETCH: begin
                if (redirect) begin
                    pc_en = 1'b1;
                    pc_d  = target;
                end else begin
                    imem_req = ~reset;
                    if (imem_gnt)
                        state_n = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        pc_en   = 1'b1;
                        pc_d    = target;
                        state_n = FETCH;
                    end else begin
                        instr       = imem_rdata;
                        FetchValidF = 1'b1;
                        if (StallF) begin
                            buf_en  = 1'b1;
                            state_n = HOLD;
                        end else begin
                            pc_en   = 1'b1;
                            state_n = FETCH;
                        end
                    end
                end else if (redirect) begin
                    // Response still in flight: swallow it in DISCARD.
                    pc_en   = 1'b1;
                    pc_d    = target;
                    state_n = DISCARD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_en   = 1'b1;
                    pc_d    = target;
                    state_n = FETCH;
                end else begin
                    instr       = hold_buf;
                    FetchValidF = 1'b1;
                    if (!StallF) begin
                        pc_en   = 1'b1;
                        state_n = FETCH;
                    end
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_en = 1'b1;
                    pc_d  = target;
                end
                if (imem_rvalid)
                    state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            hold_buf <= 32'h0;
        end else begin
            state <= state_n;
            if (buf_en)
                hold_buf <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FetchCnt  <= 32'h0;
            BubbleCnt <= 32'h0;
        end else if (!StallF) begin
            if (FetchValidF)
                FetchCnt <= FetchCnt + 32'd1;
            else
                BubbleCnt <= BubbleCnt + 32'd1;
        end
    end
`endif

endmodule
